interrupt_unit: RTL and testbench

- Upstream neighbour of the multicycle Controller FSM; produces its INT, NMI and INTD inputs.
- Synchronises and edge-detects external maskable IRQ lines and one NMI line, then holds them pending.
- Applies a software mask, prioritises requests and records the cause.
- Tracks in-service state from the Controller's isInterrupted/INA outputs until the handler signals return; supports one level of NMI nesting over INT.

---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/edge_sync.sv | 29 ++
 rtl/interrupt_unit.sv | 138 +++++++++++++
 tb/tb_interrupt_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the interrupt unit and the multicycle Controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SVC_INT = 2'd1,
        SVC_NMI = 2'd2
    } state_t;

    localparam logic INA_INT = 1'b1;
    localparam logic INA_NMI = 1'b0;

    localparam int unsigned NUM_IRQ_DEFAULT = 4;

    // A single IRQ line still needs a 1-bit cause field.
    function automatic int unsigned cause_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CAUSE_W = cause_width(NUM_IRQ_DEFAULT);

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser followed by a registered rising-edge pulse.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            last_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/interrupt_unit.sv
// Pending/mask/priority logic and in-service tracking feeding the Controller's INT, NMI, INTD.
module interrupt_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW         = cause_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmi_in,
    input  logic               maskWrite,
    input  logic [NUM_IRQ-1:0] maskData,
    input  logic               intReturn,
    input  logic               isInterrupted,
    input  logic               INA,
    output logic               INT,
    output logic               NMI,
    output logic               INTD,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic [CW-1:0]      cause,
    output logic               nmiActive
);

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] clr;
    logic               nmi_edge;
    logic               nmi_pend_q;
    logic               is_int_q;
    logic               nested_q;
    logic [CW-1:0]      sel;
    logic [CW-1:0]      cause_q;
    state_t             state_q;
    logic               take;
    logic               take_int;
    logic               take_nmi;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq_sync
        edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_irq_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (irq[i]),
            .pulse(irq_edge[i])
        );
    end

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_nmi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (nmi_in),
        .pulse(nmi_edge)
    );

    // The Controller may hold isInterrupted for several cycles; only its rise is a take.
    assign take     = isInterrupted & ~is_int_q;
    assign take_int = take & (INA == INA_INT);
    assign take_nmi = take & (INA == INA_NMI);
    assign req      = pending_q & mask_q;

    always_comb begin
        sel = '0;
        clr = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = CW'(i);
            end
        end
        if (take_int && (|req)) begin
            clr[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            mask_q     <= '0;
            nmi_pend_q <= 1'b0;
            is_int_q   <= 1'b0;
            nested_q   <= 1'b0;
            cause_q    <= '0;
            state_q    <= IDLE;
        end else begin
            is_int_q   <= isInterrupted;
            // A new edge wins over a same-cycle clear.
            pending_q  <= (pending_q & ~clr) | irq_edge;
            nmi_pend_q <= (nmi_pend_q & ~take_nmi) | nmi_edge;
            if (maskWrite) begin
                mask_q <= maskData;
            end
            if (take_int) begin
                cause_q <= sel;
            end
            case (state_q)
                IDLE: begin
                    if (take_int) begin
                        state_q <= SVC_INT;
                    end else if (take_nmi) begin
                        state_q  <= SVC_NMI;
                        nested_q <= 1'b0;
                    end
                end
                SVC_INT: begin
                    if (take_nmi) begin
                        state_q  <= SVC_NMI;
                        nested_q <= 1'b1;
                    end else if (intReturn) begin
                        state_q <= IDLE;
                    end
                end
                SVC_NMI: begin
                    if (intReturn) begin
                        state_q  <= nested_q ? SVC_INT : IDLE;
                        nested_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign INT       = (|req) & (state_q == IDLE);
    assign NMI       = nmi_pend_q;
    assign INTD      = (state_q != IDLE);
    assign nmiActive = (state_q == SVC_NMI);
    assign pending   = pending_q;
    assign mask      = mask_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_interrupt_unit;

    localparam int D = 3;  // input sample to pending update, in clock edges

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       nmi_in;
    logic       maskWrite;
    logic [3:0] maskData;
    logic       intReturn;
    logic       isInterrupted;
    logic       INA;
    logic       INT;
    logic       NMI;
    logic       INTD;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [1:0] cause;
    logic       nmiActive;

    wire [13:0] obs = {INT, NMI, INTD, nmiActive, pending, mask, cause};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: sampled input history, pending sets, and a handler stack
    bit [4:0]   samp_q[$];
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic       m_nmi;
    logic [1:0] m_cause;
    logic       m_prev_isint;
    int         m_stack[$];  // 1 = INT handler, 2 = NMI handler

    interrupt_unit #(
        .NUM_IRQ    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .nmi_in       (nmi_in),
        .maskWrite    (maskWrite),
        .maskData     (maskData),
        .intReturn    (intReturn),
        .isInterrupted(isInterrupted),
        .INA          (INA),
        .INT          (INT),
        .NMI          (NMI),
        .INTD         (INTD),
        .pending      (pending),
        .mask         (mask),
        .cause        (cause),
        .nmiActive    (nmiActive)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] model_out();
        logic busy;
        logic in_nmi;
        logic want;
        busy   = (m_stack.size() != 0);
        in_nmi = busy && (m_stack[$] == 2);
        want   = ((m_pend & m_mask) != 4'b0) && !busy;
        return {want, m_nmi, busy, in_nmi, m_pend, m_mask, m_cause};
    endfunction

    task automatic model_update();
        bit [4:0]   ev;
        logic [3:0] req;
        logic [1:0] sel;
        logic       take;
        logic       t_int;
        logic       t_nmi;
        samp_q.push_back(rst ? 5'b0 : {nmi_in, irq});
        while (samp_q.size() > D + 2) void'(samp_q.pop_front());
        ev = samp_q[samp_q.size() - 1 - D] & ~samp_q[samp_q.size() - 2 - D];
        if (rst) begin
            m_pend = '0; m_mask = '0; m_nmi = 1'b0; m_cause = '0;
            m_prev_isint = 1'b0;
            m_stack.delete();
        end else begin
            take  = isInterrupted && !m_prev_isint;
            t_int = take && INA;
            t_nmi = take && !INA;
            req   = m_pend & m_mask;
            sel   = 2'd0;
            for (int i = 3; i >= 0; i--) if (req[i]) sel = 2'(i);
            if (t_int) begin
                if (req != 4'b0) m_pend[sel] = 1'b0;
                m_cause = sel;
            end
            m_pend = m_pend | ev[3:0];
            if (t_nmi) m_nmi = 1'b0;
            m_nmi = m_nmi | ev[4];
            if (t_nmi && !(m_stack.size() != 0 && m_stack[$] == 2)) m_stack.push_back(2);
            else if (t_int && m_stack.size() == 0) m_stack.push_back(1);
            else if (intReturn && m_stack.size() != 0) void'(m_stack.pop_back());
            if (maskWrite) m_mask = maskData;
            m_prev_isint = isInterrupted;
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            model_update();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        irq = '0; nmi_in = 1'b0; maskWrite = 1'b0; maskData = '0;
        intReturn = 1'b0; isInterrupted = 1'b0; INA = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick(4);
        rst = 1'b0;
    endtask

    task automatic load_mask(logic [3:0] m);
        maskWrite = 1'b1; maskData = m;
        tick();
        maskWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        irq = 4'($urandom); nmi_in = 1'($urandom); maskWrite = 1'b1; maskData = 4'($urandom);
        intReturn = 1'($urandom); isInterrupted = 1'($urandom); INA = 1'($urandom);
        tick(2);
        idle_inputs();
        tick(3);
        vectors++;
        if (obs !== 14'd0) begin
            $display("FAIL reset_outputs: got %h want %h", obs, 14'd0);
            miscompares++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (obs !== model_out()) begin
            $display("FAIL reset_release: got %h want %h", obs, model_out());
            miscompares++;
        end
    endtask

    task automatic test_mask_gate();
        do_reset();
        irq = 4'b0100;
        tick();
        irq = '0;
        tick(2);
        vectors++;
        if (pending !== 4'b0000) begin
            $display("FAIL latency_early: pending got %b want %b", pending, 4'b0000);
            miscompares++;
        end
        tick();
        vectors++;
        if ({pending, INT} !== {4'b0100, 1'b0}) begin
            $display("FAIL masked_pending: got %b/%b want 0100/0", pending, INT);
            miscompares++;
        end
        load_mask(4'b0100);
        vectors++;
        if (INT !== 1'b1 || obs !== model_out()) begin
            $display("FAIL unmask_int: got %h want %h", obs, model_out());
            miscompares++;
        end
    endtask

    task automatic test_priority();
        do_reset();
        load_mask(4'b1111);
        irq = 4'b1010;
        tick();
        irq = '0;
        tick(3);
        isInterrupted = 1'b1; INA = 1'b1;
        tick();
        vectors++;
        if ({cause, pending, INTD, INT} !== {2'd1, 4'b1000, 1'b1, 1'b0}) begin
            $display("FAIL priority_take: got c=%0d p=%b d=%b i=%b want c=1 p=1000 d=1 i=0",
                     cause, pending, INTD, INT);
            miscompares++;
        end
        isInterrupted = 1'b0;
        tick();
        intReturn = 1'b1;
        tick();
        intReturn = 1'b0;
        vectors++;
        if ({INTD, INT} !== 2'b01 || obs !== model_out()) begin
            $display("FAIL priority_return: got %h want %h", obs, model_out());
            miscompares++;
        end
    endtask

    task automatic test_nmi_nesting();
        do_reset();
        load_mask(4'b1111);
        irq = 4'b0001;
        tick();
        irq = '0;
        tick(3);
        isInterrupted = 1'b1; INA = 1'b1;
        tick();
        isInterrupted = 1'b0;
        nmi_in = 1'b1;
        tick();
        nmi_in = 1'b0;
        tick(3);
        vectors++;
        if ({NMI, INTD, nmiActive} !== 3'b110) begin
            $display("FAIL nmi_pending_in_int: got %b want 110", {NMI, INTD, nmiActive});
            miscompares++;
        end
        isInterrupted = 1'b1; INA = 1'b0;
        tick();
        isInterrupted = 1'b0;
        vectors++;
        if ({NMI, nmiActive} !== 2'b01) begin
            $display("FAIL nmi_take: got %b want 01", {NMI, nmiActive});
            miscompares++;
        end
        intReturn = 1'b1;
        tick();
        intReturn = 1'b0;
        vectors++;
        if ({INTD, nmiActive} !== 2'b10) begin
            $display("FAIL nmi_return_nested: got %b want 10", {INTD, nmiActive});
            miscompares++;
        end
        intReturn = 1'b1;
        tick();
        intReturn = 1'b0;
        vectors++;
        if (INTD !== 1'b0 || obs !== model_out()) begin
            $display("FAIL int_return_idle: got %h want %h", obs, model_out());
            miscompares++;
        end
    endtask

    task automatic test_held_take();
        do_reset();
        load_mask(4'b1111);
        irq = 4'b0011;
        tick();
        irq = '0;
        tick(3);
        isInterrupted = 1'b1; INA = 1'b1;
        tick(4);
        isInterrupted = 1'b0;
        vectors++;
        if ({pending, cause, INTD} !== {4'b0010, 2'd0, 1'b1}) begin
            $display("FAIL held_take: got p=%b c=%0d d=%b want p=0010 c=0 d=1",
                     pending, cause, INTD);
            miscompares++;
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        load_mask(4'b1111);
        irq = 4'b0001;
        tick();
        irq = '0;
        tick(3);
        irq = 4'b0001;
        tick();
        irq = '0;
        tick(2);
        isInterrupted = 1'b1; INA = 1'b1;
        tick();
        isInterrupted = 1'b0;
        vectors++;
        if ({pending[0], cause, INTD} !== {1'b1, 2'd0, 1'b1}) begin
            $display("FAIL irq_edge_vs_clear: got p0=%b c=%0d d=%b want 1/0/1",
                     pending[0], cause, INTD);
            miscompares++;
        end
        nmi_in = 1'b1;
        tick();
        nmi_in = 1'b0;
        tick(3);
        nmi_in = 1'b1;
        tick();
        nmi_in = 1'b0;
        tick(2);
        isInterrupted = 1'b1; INA = 1'b0;
        tick();
        isInterrupted = 1'b0;
        vectors++;
        if ({NMI, nmiActive} !== 2'b11 || obs !== model_out()) begin
            $display("FAIL nmi_edge_vs_clear: got %h want %h", obs, model_out());
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_service();
        do_reset();
        load_mask(4'b1111);
        irq = 4'b1010;
        nmi_in = 1'b1;
        tick();
        irq = '0;
        nmi_in = 1'b0;
        tick(3);
        isInterrupted = 1'b1; INA = 1'b0;
        tick();
        isInterrupted = 1'b0;
        tick();
        vectors++;
        if ({nmiActive, pending} !== {1'b1, 4'b1010}) begin
            $display("FAIL nmi_service_setup: got %b want 11010", {nmiActive, pending});
            miscompares++;
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs !== 14'd0) begin
            $display("FAIL reset_mid_service: got %h want %h", obs, 14'd0);
            miscompares++;
        end
        tick(3);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int rst_cnt;
        logic [13:0] exp;
        rst_cnt = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (rst_cnt > 0) begin
                rst = 1'b1;
                rst_cnt--;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                rst_cnt = 3;
            end else begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) irq[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) nmi_in = ~nmi_in;
            maskWrite = ($urandom_range(0, 9) == 0);
            maskData  = 4'($urandom);
            intReturn = ($urandom_range(0, 7) == 0);
            exp = model_out();
            if (isInterrupted) begin
                if ($urandom_range(0, 1) == 0) isInterrupted = 1'b0;
            end else if ((exp[13] || exp[12]) && $urandom_range(0, 2) == 0) begin
                isInterrupted = 1'b1;
                INA = exp[13] && !(exp[12] && $urandom_range(0, 1) == 0);
            end
            tick();
            vectors++;
            if (obs !== model_out()) begin
                $display("FAIL random_cycle_%0d: got %h want %h", c, obs, model_out());
                miscompares++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < D + 2; i++) samp_q.push_back(5'b0);
        m_pend = '0; m_mask = '0; m_nmi = 1'b0; m_cause = '0; m_prev_isint = 1'b0;
        test_reset();
        test_mask_gate();
        test_priority();
        test_nmi_nesting();
        test_held_take();
        test_same_cycle();
        test_reset_mid_service();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
